// File: rtl/picorv32_mem_bridge.sv
// Bridge from the picorv32 native memory port to up to 16 region-decoded targets.
// Optional target timeout is enabled by defining MEM_BRIDGE_TIMEOUT_EN.
`timescale 1ns/1ps
module picorv32_mem_bridge #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned REGION_SHIFT   = 28,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       core_valid_i,
  input  logic                       core_instr_i,
  input  logic [31:0]                core_addr_i,
  input  logic [31:0]                core_wdata_i,
  input  logic [3:0]                 core_wstrb_i,
  output logic                       core_ready_o,
  output logic [31:0]                core_rdata_o,
  output logic [NUM_SLAVES-1:0]      s_valid_o,
  input  logic [NUM_SLAVES-1:0]      s_ready_i,
  output logic [31:0]                s_addr_o,
  output logic [31:0]                s_wdata_o,
  output logic [3:0]                 s_wstrb_o,
  output logic                       s_instr_o,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata_i,
  input  logic                       err_clr_i,
  output logic                       err_o,
  output logic [31:0]                err_addr_o
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("NUM_SLAVES must be 1..16");
  end
  if (REGION_SHIFT > 28) begin : g_bad_region_shift
    $error("REGION_SHIFT must be 0..28");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q;
  logic [NUM_SLAVES-1:0] s_valid_q;
  logic [31:0]           s_addr_q;
  logic [31:0]           s_wdata_q;
  logic [3:0]            s_wstrb_q;
  logic                  s_instr_q;
  logic                  core_ready_q;
  logic [31:0]           core_rdata_q;
  logic                  err_q;
  logic [31:0]           err_addr_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [31:0]           tmo_q;
`endif

  logic [3:0]  region;
  logic        ready_hit;
  logic [31:0] rdata_sel;

  assign region = core_addr_i[REGION_SHIFT +: 4];

  // s_valid_q is one-hot on the selected target, so it doubles as the select mask.
  assign ready_hit = |(s_ready_i & s_valid_q);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (s_valid_q[i]) rdata_sel = rdata_sel | s_rdata_i[32*i +: 32];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      s_valid_q    <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
      s_instr_q    <= 1'b0;
      core_ready_q <= 1'b0;
      core_rdata_q <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      core_ready_q <= 1'b0;
      // A new error event later in this block overrides the clear.
      if (err_clr_i) err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (core_valid_i) begin
            s_addr_q  <= core_addr_i;
            s_wdata_q <= core_wdata_i;
            s_wstrb_q <= core_wstrb_i;
            s_instr_q <= core_instr_i;
            if (32'(region) < NUM_SLAVES) begin
              s_valid_q <= NUM_SLAVES'(1) << region;
              state_q   <= StIssue;
`ifdef MEM_BRIDGE_TIMEOUT_EN
              tmo_q     <= '0;
`endif
            end else begin
              core_ready_q <= 1'b1;
              core_rdata_q <= ERR_RDATA;
              err_q        <= 1'b1;
              err_addr_q   <= core_addr_i;
              state_q      <= StResp;
            end
          end
        end
        StIssue: begin
          if (ready_hit) begin
            s_valid_q    <= '0;
            core_ready_q <= 1'b1;
            core_rdata_q <= rdata_sel;
            state_q      <= StResp;
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (tmo_q == TIMEOUT_CYCLES - 1) begin
            s_valid_q    <= '0;
            core_ready_q <= 1'b1;
            core_rdata_q <= ERR_RDATA;
            err_q        <= 1'b1;
            err_addr_q   <= s_addr_q;
            state_q      <= StResp;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
`endif
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign core_ready_o = core_ready_q;
  assign core_rdata_o = core_rdata_q;
  assign s_valid_o    = s_valid_q;
  assign s_addr_o     = s_addr_q;
  assign s_wdata_o    = s_wdata_q;
  assign s_wstrb_o    = s_wstrb_q;
  assign s_instr_o    = s_instr_q;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_picorv32_mem_bridge.sv
// Scoreboard bench for picorv32_mem_bridge; timeout cases only when MEM_BRIDGE_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_picorv32_mem_bridge;
  localparam int NS = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic          clk;
  logic          reset;
  logic          core_valid, core_instr, core_ready;
  logic [31:0]   core_addr, core_wdata, core_rdata;
  logic [3:0]    core_wstrb;
  logic [NS-1:0] s_valid, s_ready;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_instr;
  logic [32*NS-1:0] s_rdata;
  logic          err_clr, err;
  logic [31:0]   err_addr;

  picorv32_mem_bridge #(
    .NUM_SLAVES(NS), .REGION_SHIFT(28), .TIMEOUT_CYCLES(8), .ERR_RDATA(ERR)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .core_valid_i(core_valid), .core_instr_i(core_instr), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_wstrb_i(core_wstrb),
    .core_ready_o(core_ready), .core_rdata_o(core_rdata),
    .s_valid_o(s_valid), .s_ready_i(s_ready), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_wstrb_o(s_wstrb), .s_instr_o(s_instr), .s_rdata_i(s_rdata),
    .err_clr_i(err_clr), .err_o(err), .err_addr_o(err_addr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vcnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          vcnt = 0;
  logic [3:0]  exp_sv;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic        exp_instr;
  int          tgt_wait[NS];
  logic [31:0] tgt_data[NS];
  logic        tgt_never[NS];
  int          rcyc[NS];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Target model: each target answers after tgt_wait ISSUE cycles unless tgt_never is set.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      s_rdata[32*i +: 32] = tgt_data[i];
      if (s_valid[i]) begin
        s_ready[i] = !tgt_never[i] && (rcyc[i] == tgt_wait[i]);
        rcyc[i]++;
      end else begin
        s_ready[i] = 1'b0;
        rcyc[i] = 0;
      end
    end
  end

  // Monitor: checks the target-side bus while issuing and pops the scoreboard on core_ready.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (|s_valid) begin
          vcnt++;
          chk("s_valid", 32'(s_valid), 32'(exp_sv));
          chk("s_addr", s_addr, exp_addr);
          chk("s_wdata", s_wdata, exp_wdata);
          chk("s_wstrb", 32'(s_wstrb), 32'(exp_wstrb));
          chk("s_instr", 32'(s_instr), 32'(exp_instr));
        end
        if (core_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_core_ready: got 1, expected 0");
          end else begin
            e = exp_q.pop_front();
            chk("core_rdata", core_rdata, e.rdata);
            chk("err_at_ready", 32'(err), 32'(e.err));
            chk("s_valid_cycles", vcnt, e.vcnt);
          end
          vcnt = 0;
        end
      end
    end
  end

  task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input logic clr,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_vcnt, input int exp_lat, input string name);
    exp_t e;
    int   start;
    int   n;
    bit   done;
    exp_addr  = addr;
    exp_wdata = wdata;
    exp_wstrb = wstrb;
    exp_instr = instr;
    exp_sv    = 4'(4'd1 << addr[31:28]);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.vcnt  = exp_vcnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    core_valid = 1'b1;
    core_addr  = addr;
    core_wdata = wdata;
    core_wstrb = wstrb;
    core_instr = instr;
    err_clr    = clr;
    start = cycle;
    done = 1'b0;
    n = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      if (n >= 2) err_clr = 1'b0;
      if (core_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no core_ready in 64 cycles, expected one", name);
    end else begin
      chk({name, "_latency"}, cycle - start, exp_lat);
    end
    @(posedge clk);
    #1;
    core_valid = 1'b0;
    core_wstrb = 4'h0;
    err_clr    = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    core_valid = 1'b0;
    core_instr = 1'b0;
    core_addr = '0;
    core_wdata = '0;
    core_wstrb = '0;
    err_clr = 1'b0;
    s_ready = '0;
    s_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      tgt_wait[i] = 0;
      tgt_data[i] = '0;
      tgt_never[i] = 1'b0;
      rcyc[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    chk("rst_s_instr", 32'(s_instr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait read from target 2, instruction fetch flag set.
    tgt_data[2] = 32'h1234_5678;
    run_req(32'h2000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1, 2, "read");

    // Write to target 1 with three wait states.
    tgt_wait[1] = 3;
    tgt_data[1] = 32'h1111_0001;
    run_req(32'h1000_0004, 32'hA5A5_A5A5, 4'b0011, 1'b0, 1'b0, 32'h1111_0001, 1'b0, 4, 5,
            "write");

    // Unmapped region.
    run_req(32'h7000_0000, 32'h0, 4'h0, 1'b0, 1'b0, ERR, 1'b1, 0, 1, "decode");
    chk("decode_err_addr", err_addr, 32'h7000_0000);

    // Clear coinciding with a new decode error: error wins.
    run_req(32'h9000_0040, 32'h5555_5555, 4'hF, 1'b0, 1'b1, ERR, 1'b1, 0, 1, "decode_clr");
    chk("clr_race_err", 32'(err), 32'd1);
    chk("clr_race_err_addr", err_addr, 32'h9000_0040);

    clr_pulse();
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_keeps_err_addr", err_addr, 32'h9000_0040);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    tgt_never[3] = 1'b1;
    run_req(32'h3000_0008, 32'h0, 4'h0, 1'b0, 1'b0, ERR, 1'b1, 8, 9, "timeout");
    chk("timeout_err_addr", err_addr, 32'h3000_0008);
    clr_pulse();
    tgt_never[3] = 1'b0;
    tgt_wait[3] = 7;
    tgt_data[3] = 32'hCAFE_0003;
    run_req(32'h3000_000C, 32'h0, 4'h0, 1'b0, 1'b0, 32'hCAFE_0003, 1'b0, 8, 9, "late_ready");
    tgt_wait[3] = 0;
`endif

    // Set err again so the asynchronous reset has something to clear.
    run_req(32'hF000_0000, 32'h0, 4'h0, 1'b0, 1'b0, ERR, 1'b1, 0, 1, "decode_hi");

    tgt_never[3] = 1'b1;
    exp_sv    = 4'b1000;
    exp_addr  = 32'h3000_0020;
    exp_wdata = 32'h0;
    exp_wstrb = 4'h0;
    exp_instr = 1'b0;
    @(posedge clk);
    #1;
    core_valid = 1'b1;
    core_addr  = 32'h3000_0020;
    core_wdata = 32'h0;
    core_wstrb = 4'h0;
    core_instr = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("mid_issue_s_valid", 32'(s_valid), 32'h8);
    reset = 1'b1;
    #1;
    chk("async_rst_s_valid", 32'(s_valid), 32'd0);
    chk("async_rst_core_ready", 32'(core_ready), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_err_addr", err_addr, 32'd0);
    chk("async_rst_s_addr", s_addr, 32'd0);
    core_valid = 1'b0;
    tgt_never[3] = 1'b0;
    vcnt = 0;
    @(negedge clk);
    reset = 1'b0;

    tgt_wait[0] = 1;
    tgt_data[0] = 32'h0BAD_F00D;
    run_req(32'h0000_0100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 2, 3, "after_reset");

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
